// File: rtl/polygon_scene_buffer.sv
// rtl/polygon_scene_buffer.sv - double-buffered polygon store feeding render
// Vertices stream into a back bank; a committed scene is copied to the front bank on the next frame start.
module polygon_scene_buffer #(
    parameter int MAX_NUM_VERTICES       = 8,
    parameter int MAX_POLYGONS_ON_SCREEN = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                frame_start_in,
    input  logic                vertex_valid_in,
    output logic                vertex_ready_out,
    input  logic signed [31:0]  vertex_x_in,
    input  logic signed [31:0]  vertex_y_in,
    input  logic                vertex_last_in,
    input  logic                commit_in,
    output logic signed [31:0]  xs_out [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES],
    output logic signed [31:0]  ys_out [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]       num_sides_out [MAX_POLYGONS_ON_SCREEN],
    output logic [$clog2(MAX_POLYGONS_ON_SCREEN+1)-1:0] polygons_on_screen_out,
    output logic                swap_out,
    output logic                dropped_out
);
    localparam int VW = $clog2(MAX_NUM_VERTICES + 1);
    localparam int PW = $clog2(MAX_POLYGONS_ON_SCREEN + 1);
    localparam int VI = $clog2(MAX_NUM_VERTICES);
    localparam int PI = $clog2(MAX_POLYGONS_ON_SCREEN);
    localparam logic [VW-1:0] VMAX = VW'(MAX_NUM_VERTICES);
    localparam logic [PW-1:0] PMAX = PW'(MAX_POLYGONS_ON_SCREEN);

    typedef enum logic {LOADING, PENDING} state_t;
    state_t state;

    logic signed [31:0] back_x [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
    logic signed [31:0] back_y [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
    logic [VW-1:0]      back_sides [MAX_POLYGONS_ON_SCREEN];
    logic [VW-1:0]      vert_idx;
    logic [PW-1:0]      poly_idx;

    logic          accept, poly_full, store, close, keep, drop_evt;
    logic [VW-1:0] n_cnt, vert_nxt;
    logic [PW-1:0] poly_nxt;

    // Next-index view of the current beat, so a same-cycle commit sees the beat already applied.
    always_comb begin
        accept    = vertex_valid_in && (state == LOADING);
        poly_full = (poly_idx == PMAX);
        n_cnt     = (vert_idx < VMAX) ? vert_idx + VW'(1) : VMAX;
        store     = accept && !poly_full && (vert_idx < VMAX);
        close     = accept && !poly_full && vertex_last_in;
        keep      = close && (n_cnt >= VW'(3));
        poly_nxt  = keep ? poly_idx + PW'(1) : poly_idx;
        if (close)
            vert_nxt = '0;
        else if (accept && !poly_full)
            vert_nxt = n_cnt;
        else
            vert_nxt = vert_idx;
        drop_evt = (accept && (poly_full || (vert_idx == VMAX) || (close && !keep)))
                || (commit_in && (state == LOADING) && (vert_nxt != '0));
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                  <= LOADING;
            vertex_ready_out       <= 1'b1;
            swap_out               <= 1'b0;
            dropped_out            <= 1'b0;
            vert_idx               <= '0;
            poly_idx               <= '0;
            polygons_on_screen_out <= '0;
            for (int p = 0; p < MAX_POLYGONS_ON_SCREEN; p++) begin
                back_sides[p]    <= '0;
                num_sides_out[p] <= '0;
                for (int v = 0; v < MAX_NUM_VERTICES; v++) begin
                    back_x[p][v] <= '0;
                    back_y[p][v] <= '0;
                    xs_out[p][v] <= '0;
                    ys_out[p][v] <= '0;
                end
            end
        end else begin
            swap_out <= 1'b0;
            if (drop_evt)
                dropped_out <= 1'b1;
            case (state)
                LOADING: begin
                    if (store) begin
                        back_x[poly_idx[PI-1:0]][vert_idx[VI-1:0]] <= vertex_x_in;
                        back_y[poly_idx[PI-1:0]][vert_idx[VI-1:0]] <= vertex_y_in;
                    end
                    if (keep)
                        back_sides[poly_idx[PI-1:0]] <= n_cnt;
                    poly_idx <= poly_nxt;
                    vert_idx <= vert_nxt;
                    if (commit_in) begin
                        vert_idx         <= '0;
                        state            <= PENDING;
                        vertex_ready_out <= 1'b0;
                    end
                end
                PENDING: begin
                    // poly_idx is frozen while pending, so it is the committed polygon count.
                    if (frame_start_in) begin
                        xs_out                 <= back_x;
                        ys_out                 <= back_y;
                        num_sides_out          <= back_sides;
                        polygons_on_screen_out <= poly_idx;
                        poly_idx               <= '0;
                        vert_idx               <= '0;
                        swap_out               <= 1'b1;
                        state                  <= LOADING;
                        vertex_ready_out       <= 1'b1;
                    end
                end
                default: state <= LOADING;
            endcase
        end
    end
endmodule

// File: doc/polygon_scene_buffer.md
# polygon_scene_buffer

Double-buffered polygon store between the physics/scene engine and `render`. It accepts polygons as a stream of vertices over a valid/ready handshake into a back bank. On the first frame boundary after the engine commits a scene, the back bank becomes the front bank. The front bank drives `render`'s per-polygon vertex arrays, side counts and polygon count, which stay stable for the whole displayed frame.

## Interface
- `MAX_NUM_VERTICES`, 8: vertex slots per polygon.
- `MAX_POLYGONS_ON_SCREEN`, 4: polygon slots per bank.
- `clk_in` input 1: single clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `frame_start_in` input 1: one-cycle strobe at the start of vertical blank.
- `vertex_valid_in` input 1: a vertex beat is offered.
- `vertex_ready_out` output 1: the block can take a beat.
- `vertex_x_in` input 32 signed: world x of the vertex.
- `vertex_y_in` input 32 signed: world y of the vertex.
- `vertex_last_in` input 1: this beat is the final vertex of its polygon.
- `commit_in` input 1: one-cycle strobe marking the scene complete.
- `xs_out[MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES]` output 32 signed each: front-bank x coordinates.
- `ys_out[...][...]` output 32 signed each: front-bank y coordinates.
- `num_sides_out[MAX_POLYGONS_ON_SCREEN]` output clog2(MAX_NUM_VERTICES+1): front-bank vertex count per polygon.
- `polygons_on_screen_out` output clog2(MAX_POLYGONS_ON_SCREEN+1): number of valid front polygons.
- `swap_out` output 1: one-cycle pulse, the front bank has just changed.
- `dropped_out` output 1: sticky flag, data has been discarded.

## Operation
The block has two states.

**LOADING** (reset state)
- `vertex_ready_out`=1.
- A beat is accepted when `vertex_valid_in && vertex_ready_out`.
- Each accepted beat writes (x,y) into back slot [poly_idx][vert_idx], then increments vert_idx.
- On `vertex_last_in`:
  - If the polygon has ≥3 vertices, its count is stored in back num_sides[poly_idx], poly_idx increments, and vert_idx clears.
  - If it has fewer than 3 vertices, it is discarded: poly_idx is unchanged, vert_idx clears, and `dropped_out` sets.
- Vertex overflow: beats beyond `MAX_NUM_VERTICES` within one polygon are accepted and discarded, and `dropped_out` sets. The polygon is kept with `MAX_NUM_VERTICES` sides.
- Polygon overflow: when poly_idx==`MAX_POLYGONS_ON_SCREEN`, all further beats are accepted and discarded, and `dropped_out` sets.
- `commit_in`:
  - Any partially received polygon (beats since the last `vertex_last_in`) is discarded, and `dropped_out` sets if that polygon had any beats.
  - The back count latches poly_idx, then the state goes to PENDING.
  - A scene with zero polygons is legal.
- If an accepted beat and `commit_in` occur in the same cycle, the beat is processed first and is included in the scene.

**PENDING**
- `vertex_ready_out`=0; `commit_in` is ignored.
- On `frame_start_in`:
  - The banks swap, so front = the committed scene.
  - `swap_out` pulses.
  - The new back bank's indices reset to 0.
  - The state returns to LOADING.

**Other rules**
- `frame_start_in` during LOADING has no effect; the front bank persists, so the previous scene is redrawn.
- Front slots beyond `num_sides_out[p]`, or for p ≥ `polygons_on_screen_out`, hold unspecified values. The consumer uses only counted entries.
- Coordinates are stored unmodified; there is no clipping or arithmetic.
- `dropped_out` clears only on reset.

## Timing
- Reset, asynchronous: both banks' counts are 0, and all indices are 0.
  - `polygons_on_screen_out`=0.
  - `num_sides_out[*]`=0.
  - `xs_out`/`ys_out` are all 0.
  - `vertex_ready_out`=1, `swap_out`=0, `dropped_out`=0, state is LOADING.
- Reset mid-load or mid-PENDING discards everything; the empty front scene is shown.
- `vertex_ready_out` depends only on state, so it is registered. There is no combinational path from `vertex_valid_in`.
- Commit latency: at the edge sampling `commit_in`, the state becomes PENDING. `vertex_ready_out`=0 from the next cycle.
- Swap latency: at the edge sampling `frame_start_in` in PENDING, all front outputs change together. They are valid in the following cycle, and `swap_out`=1 for exactly that cycle.
- If `commit_in` and `frame_start_in` arrive in the same cycle, there is no swap on that frame. The swap waits for the next `frame_start_in`.
- Front outputs never change except at a swap or a reset.
- Throughput: one vertex per cycle in LOADING.

## Test plan
1. Reset, then observe: `polygons_on_screen_out`=0, `vertex_ready_out`=1, `swap_out`=0, `dropped_out`=0.
2. Stream a square (100,100),(200,100),(200,200),(100,200) with last on the 4th beat, then commit, then `frame_start_in`. Required one cycle after `frame_start_in`:
   - `swap_out`=1.
   - `polygons_on_screen_out`=1 and `num_sides_out[0]`=4.
   - xs[0]={100,200,200,100}.
3. Load a triangle, commit, and hold `frame_start_in` low. Required: `vertex_ready_out`=0 and front unchanged. Then send `frame_start_in` together with `commit_in` in LOADING on the next scene. Required: no swap until the following strobe.
4. Send a 10-vertex polygon with `MAX_NUM_VERTICES`=8. Required: `num_sides_out`=8, first 8 coordinates kept, `dropped_out`=1.
5. Send a 5th polygon with `MAX_POLYGONS_ON_SCREEN`=4, plus a 2-vertex polygon. Required: count=4, `dropped_out`=1, all beats accepted with ready held high.
6. Send `commit_in` with no beats, then `frame_start_in`. Required: `polygons_on_screen_out`=0 and `swap_out` pulses. Also assert `rst_in` while PENDING. Required: outputs return to reset values immediately.
